// File: rtl/rtc_bus_sequencer.sv
// Burst sequencer feeding the RTC bus timing generator: one en_esc/en_lect transaction per register,
// muxes address/write data onto the shared A/D bus and captures read bytes on each data window.
module rtc_bus_sequencer #(
    parameter int unsigned NREG      = 6,
    parameter logic [63:0] ADDR_LIST = 64'h0000_2625_2423_2221,
    parameter int unsigned GAP_CYC   = 3,
    parameter logic [7:0]  TIMEOUT   = 8'd120
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_wr,
    input  logic              req_rd,
    input  logic [8*NREG-1:0] wr_data,
    output logic [8*NREG-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              en_esc,
    output logic              en_lect,
    input  logic              dir_flag,
    input  logic              dat_flag,
    input  logic              cambio_est,
    input  logic              en_tristate,
    output logic [7:0]        ad_out,
    output logic              ad_oe,
    input  logic [7:0]        ad_in
);

    localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int BW = IW + 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_GAP   = 3'd2,
        S_DONE  = 3'd3,
        S_ABORT = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              mode_q, mode_d;
    logic [7:0]        wdog_q, wdog_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [8*NREG-1:0] rd_data_q, rd_data_d;
    logic              en_esc_q, en_esc_d;
    logic              en_lect_q, en_lect_d;
    logic              dat_prev_q;
    logic              cap_q, cap_d;
    logic              cap_en;
    logic [BW-1:0]     bsel;

    assign bsel = {idx_q, 3'b000};

    // One capture per transaction: dat_flag rising edge, latched off until the next RUN entry.
    assign cap_en = (state_q == S_RUN) && !mode_q && dat_flag && !dat_prev_q && !cap_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        mode_d    = mode_q;
        wdog_d    = wdog_q;
        gap_d     = gap_q;
        rd_data_d = rd_data_q;
        cap_d     = cap_q;

        unique case (state_q)
            S_IDLE: begin
                wdog_d = '0;
                if (req_wr || req_rd) begin
                    mode_d  = req_wr;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (wdog_q != TIMEOUT) wdog_d = wdog_q + 8'd1;
                if (cambio_est) begin
                    state_d = S_GAP;
                    gap_d   = '0;
                end else if (wdog_q == TIMEOUT) begin
                    state_d = S_ABORT;
                end
            end
            S_GAP: begin
                if (gap_q != GW'(GAP_CYC - 1)) begin
                    gap_d = gap_q + GW'(1);
                end else if (!cambio_est) begin
                    if (idx_q == IW'(NREG - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        wdog_d  = '0;
                        state_d = S_RUN;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (cap_en) begin
            rd_data_d[bsel +: 8] = ad_in;
            cap_d                = 1'b1;
        end
        if (state_q != S_RUN && state_d == S_RUN) cap_d = 1'b0;
    end

    // Enables are registered from next state so they drop the cycle after cambio_est.
    assign en_esc_d  = (state_d == S_RUN) &&  mode_d;
    assign en_lect_d = (state_d == S_RUN) && !mode_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            mode_q     <= 1'b0;
            wdog_q     <= '0;
            gap_q      <= '0;
            rd_data_q  <= '0;
            en_esc_q   <= 1'b0;
            en_lect_q  <= 1'b0;
            dat_prev_q <= 1'b0;
            cap_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            mode_q     <= mode_d;
            wdog_q     <= wdog_d;
            gap_q      <= gap_d;
            rd_data_q  <= rd_data_d;
            en_esc_q   <= en_esc_d;
            en_lect_q  <= en_lect_d;
            dat_prev_q <= dat_flag;
            cap_q      <= cap_d;
        end
    end

    assign rd_data = rd_data_q;
    assign en_esc  = en_esc_q;
    assign en_lect = en_lect_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign err     = (state_q == S_ABORT);

    assign ad_out = dir_flag ? ADDR_LIST[bsel +: 8] : wr_data[bsel +: 8];
    assign ad_oe  = en_tristate && (dir_flag || (dat_flag && mode_q)) && (state_q == S_RUN);

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Randomized scoreboard bench for rtc_bus_sequencer with a behavioural RTC timing-generator model.
module tb_rtc_bus_sequencer;

    localparam int          NREG    = 6;
    localparam int          GAP_CYC = 3;
    localparam int          TMO     = 120;
    localparam logic [63:0] AL      = 64'h0000_2625_2423_2221;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_wr = 1'b0, req_rd = 1'b0;
    logic [8*NREG-1:0] wr_data = '0;
    logic [8*NREG-1:0] rd_data;
    logic              busy, done, err, en_esc, en_lect, ad_oe;
    logic              dir_flag = 1'b0, dat_flag = 1'b0, cambio_est = 1'b0, en_tristate = 1'b0;
    logic [7:0]        ad_out;
    logic [7:0]        ad_in = 8'h00;

    rtc_bus_sequencer #(.NREG(NREG), .ADDR_LIST(AL), .GAP_CYC(GAP_CYC), .TIMEOUT(8'(TMO))) dut (
        .clk(clk), .reset(reset), .req_wr(req_wr), .req_rd(req_rd),
        .wr_data(wr_data), .rd_data(rd_data), .busy(busy), .done(done), .err(err),
        .en_esc(en_esc), .en_lect(en_lect), .dir_flag(dir_flag), .dat_flag(dat_flag),
        .cambio_est(cambio_est), .en_tristate(en_tristate),
        .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic wr; logic [7:0] addr; logic [7:0] data; } txn_t;
    typedef struct packed { logic is_err; logic [47:0] rd; } res_t;

    txn_t        txn_q[$];
    res_t        res_q[$];
    logic [47:0] exp_rd = '0;
    logic [7:0]  tg_base = 8'h00;
    int          tg_stall = NREG;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Timing generator model: after en_* rises, 2 idle cycles, 3 address cycles, 3 data cycles,
    // then cambio_est for 2 cycles. A stalled transaction never produces any window.
    initial begin : tg_model
        int cnt = 0, hold = 0, txn = 0, cur = 0;
        bit stalled;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                cnt = 0; hold = 0; txn = 0;
                dir_flag = 0; dat_flag = 0; en_tristate = 0; cambio_est = 0;
                continue;
            end
            if (!busy) txn = 0;
            if (en_esc || en_lect) begin
                if (cnt == 0) begin cur = txn; txn++; end
                cnt++;
            end else begin
                cnt = 0;
            end
            stalled     = (cur == tg_stall);
            dir_flag    = (cnt >= 3 && cnt <= 5) && !stalled;
            dat_flag    = (cnt >= 6 && cnt <= 8) && !stalled;
            en_tristate = dir_flag || dat_flag;
            ad_in       = dat_flag ? tg_base + 8'(cur) : 8'($urandom);
            if (cnt == 9 && !stalled) hold = 2;
            cambio_est = (hold != 0);
            if (hold != 0) hold--;
        end
    end

    // Monitor: pops the expected transaction / end-of-burst result when the DUT presents it.
    initial begin : monitor
        bit en, en_p = 0, dir_p = 0, dat_p = 0, busy_p = 0, first = 0, idle_chk = 0, have = 0;
        int low_cnt = 0, hi_cnt = 0;
        txn_t cur;
        res_t r;
        forever begin
            @(negedge clk);
            if (reset) begin
                en_p = 0; dir_p = 0; dat_p = 0; busy_p = 0; first = 0; idle_chk = 0; have = 0;
                low_cnt = 0; hi_cnt = 0;
                continue;
            end
            if (idle_chk) begin
                chk("busy_after_end", busy, 0);
                chk("end_pulse_width", done | err, 0);
                idle_chk = 0;
            end
            if (busy && !busy_p) first = 1;
            en = en_esc || en_lect;
            if (en) chk("en_exclusive", en_esc & en_lect, 0);
            if (en && !en_p) begin
                if (!first) begin
                    chk("gap_len_ok", low_cnt >= GAP_CYC, 1);
                    chk("gap_cambio_low", cambio_est, 0);
                end
                first = 0;
                if (txn_q.size() == 0) begin
                    chk("unexpected_txn", 1, 0);
                    have = 0;
                end else begin
                    cur  = txn_q.pop_front();
                    have = 1;
                    chk("en_esc", en_esc, cur.wr);
                    chk("en_lect", en_lect, !cur.wr);
                end
                hi_cnt = 0;
            end
            if (en) begin hi_cnt++; low_cnt = 0; end
            else low_cnt++;
            if (have && en) begin
                if (dir_flag && !dir_p) begin
                    chk("addr", ad_out, cur.addr);
                    chk("addr_oe", ad_oe, 1);
                end
                if (dat_flag && !dat_p && cur.wr) begin
                    chk("wdata", ad_out, cur.data);
                    chk("wdata_oe", ad_oe, 1);
                end
                if (dat_flag && !cur.wr) chk("read_oe_low", ad_oe, 0);
            end
            if (done || err) begin
                if (res_q.size() == 0) begin
                    chk("unexpected_end", 1, 0);
                end else begin
                    r = res_q.pop_front();
                    chk("end_kind", {done, err}, r.is_err ? 2'b01 : 2'b10);
                    chk("rd_data", rd_data, r.rd);
                    if (err) chk("timeout_run_cycles", (hi_cnt >= TMO) && (hi_cnt <= TMO + 1), 1);
                    if (done) chk("done_after_gap", low_cnt, GAP_CYC + 1);
                end
                have     = 0;
                idle_chk = 1;
            end
            en_p = en; dir_p = dir_flag; dat_p = dat_flag; busy_p = busy;
        end
    end

    // Reference: burst = one transaction per register up to and including a stalled one.
    task automatic push_exp(input bit wr, input logic [47:0] w, input logic [7:0] base, input int stall);
        txn_t t;
        res_t r;
        int last = (stall < NREG) ? stall : NREG - 1;
        for (int i = 0; i <= last; i++) begin
            t.wr   = wr;
            t.addr = AL[8*i +: 8];
            t.data = wr ? w[8*i +: 8] : base + 8'(i);
            txn_q.push_back(t);
            if (!wr && i < stall) exp_rd[8*i +: 8] = base + 8'(i);
        end
        r.is_err = (stall < NREG);
        r.rd     = exp_rd;
        res_q.push_back(r);
    endtask

    task automatic burst(input bit wr, input bit both, input bit poke,
                         input logic [47:0] w, input logic [7:0] base, input int stall);
        int n = 0;
        push_exp(wr, w, base, stall);
        wr_data  = w;
        tg_base  = base;
        tg_stall = stall;
        @(posedge clk); #2;
        req_wr = wr | both;
        req_rd = !wr | both;
        @(posedge clk); #2;
        req_wr = 0; req_rd = 0;
        chk("busy_start", busy, 1);
        if (poke) begin
            repeat (25) @(posedge clk);
            #2;
            if (wr) req_rd = 1; else req_wr = 1;
            @(posedge clk); #2;
            req_wr = 0; req_rd = 0;
        end
        while (busy && n < 3000) begin
            @(posedge clk); #2;
            n++;
        end
        chk("burst_finished", busy, 0);
        repeat (3) @(posedge clk);
        #2;
    endtask

    initial begin : stim
        logic [47:0] w;
        repeat (3) @(posedge clk);
        #2 reset = 0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done_err", {done, err}, 0);
        chk("rst_en", {en_esc, en_lect}, 0);
        chk("rst_rd_data", rd_data, 0);

        burst(1, 0, 0, 48'h16_09_10_12_59_48, 8'h00, NREG);
        burst(0, 0, 0, 48'h0, 8'hA0, NREG);
        chk("read_A0_A5", rd_data, 48'hA5A4A3A2A1A0);
        burst(1, 0, 0, 48'h1111_2222_3333, 8'h00, 0);
        burst(0, 0, 0, 48'h0, 8'h50, 3);
        burst(1, 1, 0, 48'hCAFE_F00D_BEEF, 8'h00, NREG);
        burst(1, 0, 1, 48'h0102_0304_0506, 8'h00, NREG);
        burst(0, 0, 1, 48'h0, 8'h70, NREG);

        for (int k = 0; k < 10; k++) begin
            w = {16'($urandom), 32'($urandom)};
            burst(1'($urandom), 0, 0, w, 8'($urandom),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NREG - 1)) : NREG);
        end

        // Reset in the middle of a read burst.
        push_exp(0, 48'h0, 8'h30, NREG);
        tg_base = 8'h30; tg_stall = NREG;
        @(posedge clk); #2 req_rd = 1;
        @(posedge clk); #2 req_rd = 0;
        repeat (30) @(posedge clk);
        #2;
        chk("pre_reset_busy", busy, 1);
        reset = 1;
        txn_q.delete();
        res_q.delete();
        exp_rd = '0;
        @(negedge clk);
        chk("midrst_en", {en_esc, en_lect}, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_rd_data", rd_data, 0);
        @(posedge clk); #2 reset = 0;
        repeat (4) @(posedge clk);
        #2;
        burst(0, 0, 0, 48'h0, 8'hC0, NREG);

        chk("txn_q_drained", txn_q.size(), 0);
        chk("res_q_drained", res_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
